// File: rtl/sort_pkg.sv
// Shared types and widths for the sort batch controller and its command handshake.
package sort_pkg;

  localparam int unsigned DataW     = 16;
  localparam int unsigned CntW      = 8;
  localparam int unsigned MinLowDef = 2;

  // Each command state covers both its REQ and WAIT phase; sort_cmd_hs tracks the phase.
  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StLoad,
    StPush,
    StSort,
    StPop,
    StEmit,
    StErr
  } state_e;

  typedef enum logic [1:0] {
    HsIdle,
    HsReq,
    HsWait
  } hs_state_e;

endpackage

// File: rtl/sort_cmd_hs.sv
// Request/acknowledge handshake for one engine command, keyed on the engine idle flag.
module sort_cmd_hs
  import sort_pkg::*;
#(
  parameter int unsigned MinLow = MinLowDef
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic abort,
  input  logic idle,
  output logic cmd,
  output logic done,
  output logic active
);

  hs_state_e  phase_q, phase_d;
  logic [7:0] low_q, low_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      phase_q <= HsIdle;
      low_q   <= '0;
    end else begin
      phase_q <= phase_d;
      low_q   <= low_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    low_d   = low_q;
    done    = 1'b0;
    unique case (phase_q)
      HsIdle: if (start) phase_d = HsReq;
      HsReq: begin
        if (!idle) begin
          phase_d = HsWait;
          low_d   = '0;
        end
      end
      HsWait: begin
        if (low_q != 8'hff) low_d = low_q + 8'd1;
        // low_q holds the low cycles already spent; the current one makes it +1
        if (idle && (32'(low_q) + 32'd1 >= MinLow)) begin
          done    = 1'b1;
          phase_d = HsIdle;
        end
      end
      default: phase_d = HsIdle;
    endcase
    if (abort) begin
      phase_d = HsIdle;
      done    = 1'b0;
    end
  end

  assign cmd    = (phase_q == HsReq);
  assign active = (phase_q != HsIdle);

endmodule

// File: rtl/sort_batch_ctrl.sv
// Streaming batch front/back end for the insertion_sort engine.
// Optional acknowledge timeout with sticky err: define SORT_BATCH_TIMEOUT_EN.
module sort_batch_ctrl
  import sort_pkg::*;
#(
  parameter int unsigned MAX_BATCH = 254,
  parameter int unsigned MIN_LOW   = MinLowDef,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DataW-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DataW-1:0] m_data,
  output logic             m_last,
  output logic             srt_push,
  output logic             srt_pop,
  output logic             srt_clear,
  output logic             srt_sort,
  output logic             srt_enable,
  output logic [DataW-1:0] srt_din,
  input  logic [DataW-1:0] srt_dout,
  input  logic             srt_idle,
  input  logic             srt_full,
  input  logic             srt_empty,
  output logic             busy,
  output logic             err
);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DataW-1:0] din_q, din_d;
  logic [DataW-1:0] mdata_q, mdata_d;
  logic             last_q, last_d;
  logic             s_ready_q, s_ready_d;
  logic             hs_start, hs_done, hs_cmd, hs_active, hs_abort, tmo_hit;

  sort_cmd_hs #(
    .MinLow (MIN_LOW)
  ) u_cmd_hs (
    .clk    (clk),
    .rstn   (rstn),
    .start  (hs_start),
    .abort  (hs_abort),
    .idle   (srt_idle),
    .cmd    (hs_cmd),
    .done   (hs_done),
    .active (hs_active)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      din_q     <= '0;
      mdata_q   <= '0;
      last_q    <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      din_q     <= din_d;
      mdata_q   <= mdata_d;
      last_q    <= last_d;
      s_ready_q <= s_ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    din_d    = din_q;
    mdata_d  = mdata_q;
    last_d   = last_q;
    hs_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          state_d = StClr;
          cnt_d   = '0;
        end
      end
      StClr: begin
        hs_start = 1'b1;
        if (hs_done) state_d = StLoad;
      end
      StLoad: begin
        if (s_valid && s_ready_q) begin
          din_d   = s_data;
          last_d  = s_last;
          cnt_d   = cnt_q + 1'b1;
          state_d = StPush;
        end else if (!s_ready_q) begin
          // s_ready was withheld because the engine reported full
          state_d = StSort;
        end
      end
      StPush: begin
        hs_start = 1'b1;
        if (hs_done) begin
          state_d = (last_q || cnt_q == CntW'(MAX_BATCH)) ? StSort : StLoad;
        end
      end
      StSort: begin
        hs_start = 1'b1;
        if (hs_done) state_d = (cnt_q == '0) ? StIdle : StPop;
      end
      StPop: begin
        hs_start = 1'b1;
        if (hs_done) begin
          mdata_d = srt_dout;
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (m_ready) state_d = (cnt_q != '0) ? StPop : StIdle;
      end
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase
    if (tmo_hit) state_d = StErr;
    s_ready_d = (state_d == StLoad) && !srt_full;
  end

`ifdef SORT_BATCH_TIMEOUT_EN
  logic [9:0] tmo_q;
  logic       err_q;

  assign tmo_hit  = hs_active && (tmo_q == 10'(TIMEOUT - 1));
  assign hs_abort = tmo_hit;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= (hs_active && !hs_done) ? tmo_q + 1'b1 : '0;
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic [10:0] unused_tmo;

  assign tmo_hit    = 1'b0;
  assign hs_abort   = 1'b0;
  assign err        = 1'b0;
  assign unused_tmo = {hs_active, 10'(TIMEOUT)};
`endif

  logic unused_empty;
  assign unused_empty = srt_empty;

  assign srt_clear  = hs_cmd && (state_q == StClr);
  assign srt_push   = hs_cmd && (state_q == StPush);
  assign srt_sort   = hs_cmd && (state_q == StSort);
  assign srt_pop    = hs_cmd && (state_q == StPop);
  assign srt_enable = 1'b1;
  assign srt_din    = din_q;
  assign s_ready    = s_ready_q;
  assign m_valid    = (state_q == StEmit);
  assign m_last     = m_valid && (cnt_q == '0);
  assign m_data     = mdata_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_sort_batch_ctrl.sv
// Self-checking bench for sort_batch_ctrl with a behavioural insertion_sort engine.
module tb_sort_batch_ctrl;

  localparam int unsigned MaxB = 4;
  localparam int unsigned MinL = 2;
  localparam int unsigned Tmo  = 20;

  logic        clk, rstn;
  logic        s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic [15:0] s_data, m_data, srt_din, srt_dout;
  logic        srt_push, srt_pop, srt_clear, srt_sort, srt_enable;
  logic        srt_idle, srt_full, srt_empty, busy, err;

  int n_chk, n_fail;

  sort_batch_ctrl #(
    .MAX_BATCH (MaxB),
    .MIN_LOW   (MinL),
    .TIMEOUT   (Tmo)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .srt_push   (srt_push),
    .srt_pop    (srt_pop),
    .srt_clear  (srt_clear),
    .srt_sort   (srt_sort),
    .srt_enable (srt_enable),
    .srt_din    (srt_din),
    .srt_dout   (srt_dout),
    .srt_idle   (srt_idle),
    .srt_full   (srt_full),
    .srt_empty  (srt_empty),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Engine model: acknowledges a command by dropping idle, stays busy, then
  // raises idle once every command line is low again. Pops come out ascending.
  logic [15:0] e_mem[$];
  logic        e_idle, e_full, e_empty, stuck_sort;
  logic [15:0] e_dout;
  int          e_cnt, n_clear, n_push, n_sort, n_pop;

  initial begin
    e_idle = 1'b1; e_full = 1'b0; e_empty = 1'b1; e_dout = '0; e_cnt = 0;
    n_clear = 0; n_push = 0; n_sort = 0; n_pop = 0;
  end

  always @(posedge clk) begin
    e_full  <= (e_mem.size() >= 255);
    e_empty <= (e_mem.size() == 0);
    if (e_cnt > 0) begin
      e_cnt <= e_cnt - 1;
    end else if (!e_idle) begin
      if (!(srt_clear || srt_push || srt_sort || srt_pop)) e_idle <= 1'b1;
    end else if (srt_clear) begin
      e_mem.delete();
      n_clear <= n_clear + 1; e_idle <= 1'b0; e_cnt <= 2;
    end else if (srt_push) begin
      e_mem.push_back(srt_din);
      n_push <= n_push + 1; e_idle <= 1'b0; e_cnt <= 1;
    end else if (srt_sort && !stuck_sort) begin
      e_mem.sort();
      n_sort <= n_sort + 1; e_idle <= 1'b0; e_cnt <= 5;
    end else if (srt_pop) begin
      if (e_mem.size() > 0) e_dout <= e_mem.pop_front();
      n_pop <= n_pop + 1; e_idle <= 1'b0; e_cnt <= 1;
    end
  end

  assign srt_idle  = e_idle;
  assign srt_full  = e_full;
  assign srt_empty = e_empty;
  assign srt_dout  = e_dout;

  // Scoreboard: batches close on s_last or MaxB words; each emits sorted, last on final.
  logic [15:0] cur[$];
  logic [15:0] exp_d[$];
  logic        exp_l[$];
  logic [15:0] out_seen[$];

  initial begin
    logic [3:0]  c, prev_c;
    int          low_run[4];
    logic        prev_mv, prev_mr, prev_ml, prev_hs, prev_rst;
    logic [15:0] prev_md;
    prev_c = '0; prev_mv = 0; prev_mr = 0; prev_ml = 0; prev_hs = 0; prev_rst = 0; prev_md = '0;
    for (int i = 0; i < 4; i++) low_run[i] = 100;
    forever begin
      @(negedge clk);
      c = {srt_clear, srt_push, srt_sort, srt_pop};
      chk("cmd_onehot", 32'($countones(c) <= 1), 32'd1);
      for (int i = 0; i < 4; i++) begin
        if (c[i]) begin
          if (!prev_c[i]) chk("cmd_min_low", 32'(low_run[i] >= int'(MinL)), 32'd1);
          low_run[i] = 0;
        end else begin
          low_run[i]++;
        end
      end
      prev_c = c;
      if (!rstn) begin
        cur.delete(); exp_d.delete(); exp_l.delete();
      end else begin
        if (prev_rst && prev_hs) chk("s_ready_one_cycle", 32'(s_ready), 32'd0);
        if (prev_rst && prev_mv && !prev_mr) begin
          chk("hold_valid", 32'(m_valid), 32'd1);
          chk("hold_data", 32'(m_data), 32'(prev_md));
          chk("hold_last", 32'(m_last), 32'(prev_ml));
        end
        if (s_valid && s_ready) begin
          cur.push_back(s_data);
          if (s_last || cur.size() == MaxB) begin
            cur.sort();
            foreach (cur[i]) begin
              exp_d.push_back(cur[i]);
              exp_l.push_back(i == cur.size() - 1);
            end
            cur.delete();
          end
        end
        if (m_valid && m_ready) begin
          out_seen.push_back(m_data);
          if (exp_d.size() == 0) begin
            chk("unexpected_beat", 32'd1, 32'd0);
          end else begin
            chk("beat_data", 32'(m_data), 32'(exp_d.pop_front()));
            chk("beat_last", 32'(m_last), 32'(exp_l.pop_front()));
          end
        end
      end
      prev_mv = m_valid; prev_mr = m_ready; prev_md = m_data; prev_ml = m_last;
      prev_hs = s_valid && s_ready; prev_rst = rstn;
    end
  end

  task automatic send(input logic [15:0] d, input logic last);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    @(negedge clk);
    while (!s_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("back_to_idle", 32'(busy), 32'd0);
  endtask

  task automatic wait_sort(input logic level);
    int n;
    n = 0;
    @(negedge clk);
    while (srt_sort !== level && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("sort_level_seen", 32'(srt_sort), 32'(level));
  endtask

  task automatic check_seq(input string name, input logic [15:0] q[$]);
    chk({name, "_len"}, 32'(out_seen.size()), 32'(q.size()));
    for (int i = 0; i < q.size() && i < out_seen.size(); i++)
      chk(name, 32'(out_seen[i]), 32'(q[i]));
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0, p0, s0, o0, pop0;
    logic [15:0] seq[$];
    s_valid = 0; s_data = '0; s_last = 0; m_ready = 1'b1; stuck_sort = 1'b0; rstn = 1'b0;
    n_chk = 0; n_fail = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_cmds", 32'({srt_clear, srt_push, srt_sort, srt_pop}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_srt_din", 32'(srt_din), 32'd0);
    chk("rst_enable", 32'(srt_enable), 32'd1);
    @(posedge clk); #1 rstn = 1'b1;

    // Batch 5,3,9,1 with the sink stalled for 7 cycles on the first beat
    c0 = n_clear; p0 = n_push; s0 = n_sort; o0 = n_pop;
    out_seen.delete();
    m_ready = 1'b0;
    send(16'd5, 1'b0); send(16'd3, 1'b0); send(16'd9, 1'b0); send(16'd1, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!m_valid && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    chk("first_beat_valid", 32'(m_valid), 32'd1);
    pop0 = n_pop;
    repeat (7) @(negedge clk);
    chk("stall_no_pop", 32'(n_pop - pop0), 32'd0);
    chk("stall_data", 32'(m_data), 32'd1);
    chk("stall_last", 32'(m_last), 32'd0);
    @(posedge clk); #1 m_ready = 1'b1;
    wait_idle();
    chk("b1_clears", 32'(n_clear - c0), 32'd1);
    chk("b1_pushes", 32'(n_push - p0), 32'd4);
    chk("b1_sorts", 32'(n_sort - s0), 32'd1);
    chk("b1_pops", 32'(n_pop - o0), 32'd4);
    chk("b1_sb_empty", 32'(exp_d.size()), 32'd0);
    seq = '{16'd1, 16'd3, 16'd5, 16'd9};
    check_seq("b1_order", seq);

    // Six words without s_last: cut after four, words 5-6 open a second batch
    c0 = n_clear; p0 = n_push; s0 = n_sort;
    out_seen.delete();
    send(16'd7, 1'b0); send(16'd2, 1'b0); send(16'd8, 1'b0);
    send(16'd4, 1'b0); send(16'd6, 1'b0); send(16'd5, 1'b0);
    s_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("cut_clears", 32'(n_clear - c0), 32'd2);
    chk("cut_pushes", 32'(n_push - p0), 32'd6);
    chk("cut_sorts", 32'(n_sort - s0), 32'd1);
    chk("cut_still_busy", 32'(busy), 32'd1);
    seq = '{16'd2, 16'd4, 16'd7, 16'd8};
    check_seq("cut_order", seq);
    pulse_reset();

    // Back-to-back batches with s_valid held high
    c0 = n_clear;
    out_seen.delete();
    send(16'd20, 1'b0); send(16'd11, 1'b0); send(16'd15, 1'b1);
    send(16'd3, 1'b0); send(16'd30, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_idle();
    chk("b2b_clears", 32'(n_clear - c0), 32'd2);
    chk("b2b_sb_empty", 32'(exp_d.size()), 32'd0);
    seq = '{16'd11, 16'd15, 16'd20, 16'd3, 16'd30};
    check_seq("b2b_order", seq);

    // Reset while the engine is still running the sort
    send(16'd10, 1'b0); send(16'd4, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_sort(1'b1);
    wait_sort(1'b0);
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_cmds", 32'({srt_clear, srt_push, srt_sort, srt_pop}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_rst_stays_idle", 32'(busy), 32'd0);

    // Engine never acknowledges the sort
    stuck_sort = 1'b1;
    send(16'd42, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_sort(1'b1);
`ifdef SORT_BATCH_TIMEOUT_EN
    repeat (Tmo - 1) @(negedge clk);
    chk("tmo_err_before", 32'(err), 32'd0);
    @(negedge clk);
    chk("tmo_err_set", 32'(err), 32'd1);
    chk("tmo_cmd_dropped", 32'(srt_sort), 32'd0);
    repeat (5) @(negedge clk);
    chk("tmo_err_busy", 32'(busy), 32'd1);
    chk("tmo_err_sticky", 32'(err), 32'd1);
`else
    repeat (40) @(negedge clk);
    chk("stuck_sort_req", 32'(srt_sort), 32'd1);
    chk("stuck_busy", 32'(busy), 32'd1);
    chk("stuck_no_err", 32'(err), 32'd0);
`endif
    pulse_reset();
    stuck_sort = 1'b0;
    @(negedge clk);
    chk("final_err", 32'(err), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
